// File: rtl/decimating_averager.sv
// Block averager: sums 2^log2_ratio accepted samples and emits their mean under valid/ready.
// Define DECIM_ROUND_EN for round-half-up with saturation; otherwise the mean is truncated.
module decimating_averager #(
    parameter int word_size  = 8,
    parameter int log2_ratio = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [word_size-1:0]  Data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [word_size-1:0]  Data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [log2_ratio-1:0] block_count
);

    localparam int AW = word_size + log2_ratio;
    localparam logic [log2_ratio-1:0] LAST_COUNT = '1;

    logic [AW-1:0]         acc_q, acc_d;
    logic [log2_ratio-1:0] count_q, count_d;
    logic [word_size-1:0]  data_out_q, data_out_d;
    logic                  out_valid_q, out_valid_d;

    logic                  block_last;
    logic                  accept;
    logic [AW-1:0]         sum;
    logic [word_size-1:0]  result;

    assign block_last = (count_q == LAST_COUNT);
    // Only the block-completing sample needs a free output slot.
    assign in_ready   = !(out_valid_q && !out_ready && block_last);
    assign accept     = in_valid && in_ready;
    assign sum        = acc_q + AW'(Data_in);

`ifdef DECIM_ROUND_EN
    localparam logic [AW:0] HALF_LSB = (AW + 1)'(1) << (log2_ratio - 1);
    logic [AW:0]        sum_rounded;
    logic [word_size:0] quotient;

    assign sum_rounded = {1'b0, sum} + HALF_LSB;
    assign quotient    = sum_rounded[AW:log2_ratio];
    assign result      = quotient[word_size] ? '1 : quotient[word_size-1:0];
`else
    assign result = sum[AW-1:log2_ratio];
`endif

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            data_out_d  = '0;
        end

        // A completing sample overrides the consume above, so a same-cycle
        // handoff keeps out_valid high with the fresh result.
        if (accept) begin
            if (block_last) begin
                acc_d       = '0;
                count_d     = '0;
                data_out_d  = result;
                out_valid_d = 1'b1;
            end else begin
                acc_d   = sum;
                count_d = count_q + log2_ratio'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q       <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign block_count = count_q;

endmodule
